// File: rtl/trn_tx_arbiter_pkg.sv
// Shared TLP format/type encodings and the transmit arbiter state encodings.
// Latency: n/a (constants only).
// Backpressure: n/a.
package trn_tx_arbiter_pkg;

    // TLP fmt field
    localparam logic [1:0] TLP_FMT_3DW_NODATA = 2'b00;
    localparam logic [1:0] TLP_FMT_4DW_NODATA = 2'b01;
    localparam logic [1:0] TLP_FMT_3DW_DATA   = 2'b10;
    localparam logic [1:0] TLP_FMT_4DW_DATA   = 2'b11;

    // TLP type field
    localparam logic [4:0] TLP_TYPE_MEM = 5'b00000;
    localparam logic [4:0] TLP_TYPE_CPL = 5'b01010;

    // Transmit arbiter states, one-hot
    localparam logic [7:0] ARB_IDLE     = 8'h01;
    localparam logic [7:0] ARB_GRANT    = 8'h02;
    localparam logic [7:0] ARB_WAIT_DRV = 8'h04;
    localparam logic [7:0] ARB_BUSY     = 8'h08;
    localparam logic [7:0] ARB_TURN     = 8'h10;

endpackage

// File: rtl/trn_tx_arbiter_rr_pick.sv
// Round-robin pick: first set request at or after rr_ptr, wrapping modulo NUM_REQ.
// Latency: combinational.
// Backpressure: none; the caller decides when to act on the winner.
module trn_tx_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_vld
);

    logic [IDX_W:0] pos;
    logic           found;

    // Walk the rotated request vector from rr_ptr; first hit wins, mapped back to absolute index
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        pos     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (pos >= (IDX_W+1)'(NUM_REQ)) begin
                pos = pos - (IDX_W+1)'(NUM_REQ);
            end
            if (!found && req[pos[IDX_W-1:0]]) begin
                found                   = 1'b1;
                win_oh[pos[IDX_W-1:0]]  = 1'b1;
                win_idx                 = pos[IDX_W-1:0];
            end
        end
        win_vld = found;
    end

endmodule

// File: rtl/trn_tx_arbiter.sv
// Round-robin owner arbiter for the shared trn_t*/cfg_interrupt transmit path.
// Latency: grant pulse 1 cycle after request in IDLE; 2 dead cycles after owner releases.
// Backpressure: owner holds the path as long as driving_interface stays high; optional
//   ARB_GRANT_TIMEOUT_EN reclaims a grant that is never taken up.
module trn_tx_arbiter
    import trn_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               trn_clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_ep,
    input  logic [NUM_REQ-1:0] driving_interface,
    output logic [NUM_REQ-1:0] my_turn,
    output logic [NUM_REQ-1:0] owner_oh,
    output logic               owner_valid,
    output logic               protocol_err
`ifdef ARB_GRANT_TIMEOUT_EN
    ,
    output logic               grant_timeout
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("trn_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    logic [7:0]         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   next_ptr;
    logic [NUM_REQ-1:0] win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic               win_vld;
    logic               owner_drv;
    logic               tmo_hit;

    trn_tx_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req     (req_ep),
        .rr_ptr  (rr_ptr),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    assign owner_drv = |(driving_interface & owner_oh);

    // Priority moves to the port after the winner, wrapping at NUM_REQ
    always_comb begin
        next_ptr = (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + IDX_W'(1);
    end

`ifdef ARB_GRANT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES+1);
    logic [CNT_W-1:0] wait_cnt;

    // Owner driving on the terminal-count cycle beats the timeout
    assign tmo_hit = (state == ARB_WAIT_DRV) && !owner_drv &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES-1));

    // Count cycles spent in WAIT_DRV; zero everywhere else so each entry starts fresh
    always_ff @(posedge trn_clk) begin
        if (reset) begin
            wait_cnt      <= '0;
            grant_timeout <= 1'b0;
        end else begin
            grant_timeout <= tmo_hit;
            if (state == ARB_WAIT_DRV) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Ownership FSM: grant pulse, wait for the owner to drive, hold, then one dead turnaround cycle
    always_ff @(posedge trn_clk) begin
        if (reset) begin
            state       <= ARB_IDLE;
            rr_ptr      <= '0;
            my_turn     <= '0;
            owner_oh    <= '0;
            owner_valid <= 1'b0;
        end else begin
            my_turn <= '0;
            case (state)
                ARB_IDLE: begin
                    if (win_vld) begin
                        my_turn     <= win_oh;
                        owner_oh    <= win_oh;
                        owner_valid <= 1'b1;
                        rr_ptr      <= next_ptr;
                        state       <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    state <= ARB_WAIT_DRV;
                end
                ARB_WAIT_DRV: begin
                    if (owner_drv) begin
                        state <= ARB_BUSY;
                    end else if (tmo_hit) begin
                        state <= ARB_TURN;
                    end
                end
                ARB_BUSY: begin
                    if (!owner_drv) begin
                        state <= ARB_TURN;
                    end
                end
                ARB_TURN: begin
                    owner_oh    <= '0;
                    owner_valid <= 1'b0;
                    state       <= ARB_IDLE;
                end
                default: begin
                    owner_oh    <= '0;
                    owner_valid <= 1'b0;
                    state       <= ARB_IDLE;
                end
            endcase
        end
    end

    // Sticky flag: someone other than the owner is driving the shared path
    always_ff @(posedge trn_clk) begin
        if (reset) begin
            protocol_err <= 1'b0;
        end else if (|(driving_interface & ~owner_oh)) begin
            protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_trn_tx_arbiter.sv
// Scoreboard bench for trn_tx_arbiter with simple requester models.
// Latency: expected grant cycles are hand-derived from the request cycle.
// Backpressure: requester models drive driving_interface for a programmed hold time.
module tb_trn_tx_arbiter;

    logic       trn_clk = 1'b0;
    logic       reset;
    logic [3:0] req_ep;
    logic [3:0] driving_interface;
    logic [3:0] my_turn;
    logic [3:0] owner_oh;
    logic       owner_valid;
    logic       protocol_err;
`ifdef ARB_GRANT_TIMEOUT_EN
    logic       grant_timeout;
`endif

    trn_tx_arbiter #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .trn_clk           (trn_clk),
        .reset             (reset),
        .req_ep            (req_ep),
        .driving_interface (driving_interface),
        .my_turn           (my_turn),
        .owner_oh          (owner_oh),
        .owner_valid       (owner_valid),
        .protocol_err      (protocol_err)
`ifdef ARB_GRANT_TIMEOUT_EN
        ,
        .grant_timeout     (grant_timeout)
`endif
    );

    always #5 trn_clk = ~trn_clk;

    typedef struct {
        logic [3:0] oh;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   mcyc  = 0;

    int         hold[4];
    int         drv_left[4];
    logic [3:0] drv_wait;
    logic [3:0] persist;
    logic [3:0] inj;
    logic [3:0] bfm_drv;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_grant(input logic [3:0] oh, input int at);
        exp_t e;
        e.oh  = oh;
        e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic bfm_clear();
        for (int i = 0; i < 4; i++) begin
            drv_left[i] = 0;
        end
        drv_wait          = '0;
        persist           = '0;
        inj               = '0;
        bfm_drv           = '0;
        req_ep            = '0;
        driving_interface = '0;
    endtask

    // Requester models: drop req on grant, drive from the next cycle for hold[i] cycles
    task automatic bfm_step();
        for (int i = 0; i < 4; i++) begin
            if (drv_wait[i]) begin
                drv_left[i] = hold[i];
                drv_wait[i] = 1'b0;
            end
            if (drv_left[i] > 0) begin
                bfm_drv[i]  = 1'b1;
                drv_left[i] = drv_left[i] - 1;
            end else begin
                bfm_drv[i] = 1'b0;
            end
            if (my_turn[i] === 1'b1) begin
                drv_wait[i] = 1'b1;
                if (!persist[i]) req_ep[i] = 1'b0;
            end
        end
        driving_interface = bfm_drv | inj;
    endtask

    task automatic tick();
        @(negedge trn_clk);
        cyc++;
        bfm_step();
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    // Monitor: every grant pulse is matched against the next expected grant
    initial begin
        exp_t e;
        forever begin
            @(negedge trn_clk);
            mcyc++;
            if (my_turn !== 4'b0000 && my_turn !== 4'bxxxx) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_grant: got %0h expected none (cycle %0d)", my_turn, mcyc);
                end else begin
                    e = sb.pop_front();
                    chk("grant_oh", my_turn, e.oh);
                    chk("grant_cycle", mcyc, e.cyc);
                    chk("owner_at_grant", owner_oh, e.oh);
                    chk("owner_valid_at_grant", owner_valid, 1);
                end
            end else if (sb.size() > 0 && sb[0].cyc < mcyc) begin
                e = sb.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL missed_grant: got none expected %0h at cycle %0d", e.oh, e.cyc);
            end
        end
    end

    initial begin
        int t;
        for (int i = 0; i < 4; i++) hold[i] = 5;
        reset = 1'b1;
        bfm_clear();
        tick();
        tick();
        chk("rst_my_turn", my_turn, 0);
        chk("rst_owner_oh", owner_oh, 0);
        chk("rst_owner_valid", owner_valid, 0);
        chk("rst_protocol_err", protocol_err, 0);
`ifdef ARB_GRANT_TIMEOUT_EN
        chk("rst_grant_timeout", grant_timeout, 0);
`endif
        reset = 1'b0;
        tick();

        // Single requester on port 2, drives t+2..t+10
        t = cyc;
        hold[2] = 9;
        req_ep[2] = 1'b1;
        expect_grant(4'b0100, t + 1);
        run_to(t + 2);
        chk("a_pulse_single_cycle", my_turn, 0);
        chk("a_owner_wait", owner_oh, 4'b0100);
        run_to(t + 12);
        chk("a_owner_turn", owner_oh, 4'b0100);
        run_to(t + 13);
        chk("a_owner_cleared", owner_oh, 0);
        chk("a_owner_valid_cleared", owner_valid, 0);
        run_to(t + 14);
        hold[2] = 5;

        // Reset, then all four request together; port 0 re-requests once
        reset = 1'b1;
        tick();
        reset = 1'b0;
        t = cyc;
        req_ep = 4'b1111;
        expect_grant(4'b0001, t + 1);
        expect_grant(4'b0010, t + 10);
        expect_grant(4'b0100, t + 19);
        expect_grant(4'b1000, t + 28);
        expect_grant(4'b0001, t + 37);
        run_to(t + 2);
        req_ep[0] = 1'b1;
        run_to(t + 46);

        // Port 3 keeps requesting, port 1 asks once during port 3's ownership
        t = cyc;
        persist[3] = 1'b1;
        req_ep[3] = 1'b1;
        expect_grant(4'b1000, t + 1);
        expect_grant(4'b0010, t + 10);
        expect_grant(4'b1000, t + 19);
        run_to(t + 3);
        req_ep[1] = 1'b1;
        run_to(t + 19);
        persist[3] = 1'b0;
        req_ep[3] = 1'b0;
        run_to(t + 28);

        // Non-owner port 2 drives while port 0 owns
        t = cyc;
        chk("d_perr_before", protocol_err, 0);
        req_ep[0] = 1'b1;
        expect_grant(4'b0001, t + 1);
        run_to(t + 3);
        inj = 4'b0100;
        driving_interface = bfm_drv | inj;
        run_to(t + 4);
        inj = 4'b0000;
        chk("d_perr_set", protocol_err, 1);
        run_to(t + 8);
        chk("d_owner_turn", owner_oh, 4'b0001);
        run_to(t + 9);
        chk("d_owner_cleared", owner_oh, 0);
        chk("d_perr_sticky", protocol_err, 1);
        run_to(t + 10);

        // Reset while port 1 is busy; first grant afterwards goes to lowest index
        t = cyc;
        req_ep[1] = 1'b1;
        expect_grant(4'b0010, t + 1);
        run_to(t + 5);
        chk("e_owner_busy", owner_oh, 4'b0010);
        reset = 1'b1;
        bfm_clear();
        run_to(t + 6);
        chk("e_rst_my_turn", my_turn, 0);
        chk("e_rst_owner_oh", owner_oh, 0);
        chk("e_rst_owner_valid", owner_valid, 0);
        chk("e_rst_perr", protocol_err, 0);
        reset = 1'b0;
        req_ep = 4'b1010;
        expect_grant(4'b0010, t + 7);
        expect_grant(4'b1000, t + 16);
        run_to(t + 26);

`ifdef ARB_GRANT_TIMEOUT_EN
        // Port 1 granted but never drives; port 2 waits behind it
        t = cyc;
        hold[1] = 0;
        req_ep[1] = 1'b1;
        expect_grant(4'b0010, t + 1);
        run_to(t + 3);
        hold[2] = 3;
        req_ep[2] = 1'b1;
        expect_grant(4'b0100, t + 12);
        run_to(t + 9);
        chk("f_tmo_before", grant_timeout, 0);
        run_to(t + 10);
        chk("f_tmo_pulse", grant_timeout, 1);
        run_to(t + 11);
        chk("f_tmo_after", grant_timeout, 0);
        run_to(t + 20);
`endif

        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
